// File: rtl/race_pkg.sv
// Shared types and defaults for the race sequencer and its neighbours.
// Pure declarations: no latency and no handshake.
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACE      = 2'd2,
    ST_FINISH    = 2'd3
  } state_e;

  localparam int DEF_TW       = 20;
  localparam int DEF_NUM_CP   = 4;
  localparam int DEF_NUM_LAPS = 3;

  localparam logic [1:0] CD_START = 2'd3;

endpackage

// File: rtl/race_sequencer_if.sv
// Race control bundle: game-state level and checkpoint pulses in, HUD/motion status out.
// Plain wires with no handshake; the sequencer registers every output it drives.
interface race_sequencer_if
  import race_pkg::*;
#(
  parameter int NUM_CP = DEF_NUM_CP,
  parameter int TW     = DEF_TW
);
  logic              race_en;
  logic [NUM_CP-1:0] cp_hit;
  logic [1:0]        state;
  logic [1:0]        cd_digit;
  logic              go;
  logic              player_enable;
  logic [1:0]        lap_count;
  logic [TW-1:0]     lap_time_ms;
  logic [TW-1:0]     last_lap_ms;
  logic [TW-1:0]     best_lap_ms;
  logic              best_valid;
  logic              finished;

  modport master (
    output race_en, cp_hit,
    input  state, cd_digit, go, player_enable, lap_count,
           lap_time_ms, last_lap_ms, best_lap_ms, best_valid, finished
  );

  modport slave (
    input  race_en, cp_hit,
    output state, cd_digit, go, player_enable, lap_count,
           lap_time_ms, last_lap_ms, best_lap_ms, best_valid, finished
  );
endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV cycles while en is high.
// Counter is held at zero whenever en is low; no backpressure.
module ms_tick_gen #(
  parameter int TICK_DIV = 65000
) (
  input  logic pclk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en)               cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else                   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/race_sequencer.sv
// Race flow: 3-2-1 countdown, ordered-checkpoint lap counting, lap timing, finish.
// Outputs registered; checkpoint pulses act on the next edge; no backpressure.
module race_sequencer
  import race_pkg::*;
#(
  parameter int TICK_DIV = 65000,
  parameter int STEP_MS  = 1000,
  parameter int NUM_CP   = DEF_NUM_CP,
  parameter int NUM_LAPS = DEF_NUM_LAPS,
  parameter int TW       = DEF_TW
) (
  input  logic             pclk,
  input  logic             rst,
  race_sequencer_if.slave  bus
);
  localparam int CPW = $clog2(NUM_CP + 1);
  localparam int SW  = $clog2(STEP_MS + 1);

  state_e          state_q, state_d;
  logic            race_en_q;
  logic [1:0]      cd_q, cd_d;
  logic [SW-1:0]   step_q, step_d;
  logic [CPW-1:0]  next_cp_q, next_cp_d;
  logic [1:0]      lap_count_q, lap_count_d;
  logic [TW-1:0]   lap_time_q, lap_time_d;
  logic [TW-1:0]   last_q, last_d;
  logic [TW-1:0]   best_q, best_d;
  logic            best_valid_q, best_valid_d;
  logic            go_q, go_d;
  logic            fin_q, fin_d;
  logic            tick;
  logic            cp_adv;
  logic            lap_done;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .pclk (pclk),
    .rst  (rst),
    .en   ((state_q == ST_COUNTDOWN) || (state_q == ST_RACE)),
    .tick (tick)
  );

  // Only the bit matching the expected checkpoint can advance, once per cycle.
  always_comb begin
    cp_adv = 1'b0;
    for (int i = 1; i < NUM_CP; i++) begin
      if (next_cp_q == CPW'(i) && bus.cp_hit[i]) cp_adv = 1'b1;
    end
  end

  assign lap_done = (next_cp_q == CPW'(NUM_CP)) && bus.cp_hit[0];

  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    step_d       = step_q;
    next_cp_d    = next_cp_q;
    lap_count_d  = lap_count_q;
    lap_time_d   = lap_time_q;
    last_d       = last_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    go_d         = 1'b0;
    fin_d        = 1'b0;

    if (!bus.race_en) begin
      state_d     = ST_IDLE;
      cd_d        = '0;
      step_d      = '0;
      lap_count_d = '0;
      lap_time_d  = '0;
      next_cp_d   = CPW'(1);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!race_en_q) begin
            state_d     = ST_COUNTDOWN;
            cd_d        = CD_START;
            step_d      = '0;
            lap_count_d = '0;
            lap_time_d  = '0;
            next_cp_d   = CPW'(1);
          end
        end
        ST_COUNTDOWN: begin
          if (tick) begin
            if (step_q == SW'(STEP_MS - 1)) begin
              step_d = '0;
              if (cd_q == 2'd1) begin
                state_d    = ST_RACE;
                go_d       = 1'b1;
                cd_d       = '0;
                lap_time_d = '0;
              end else begin
                cd_d = cd_q - 2'd1;
              end
            end else begin
              step_d = step_q + SW'(1);
            end
          end
        end
        ST_RACE: begin
          if (tick && (lap_time_q != '1)) lap_time_d = lap_time_q + TW'(1);
          if (cp_adv) next_cp_d = next_cp_q + CPW'(1);
          // Completion stores the pre-tick time and restarts the lap at zero.
          if (lap_done) begin
            last_d       = lap_time_q;
            if (!best_valid_q || (lap_time_q < best_q)) best_d = lap_time_q;
            best_valid_d = 1'b1;
            lap_count_d  = lap_count_q + 2'd1;
            next_cp_d    = CPW'(1);
            lap_time_d   = '0;
            if (lap_count_q == 2'(NUM_LAPS - 1)) begin
              state_d = ST_FINISH;
              fin_d   = 1'b1;
            end
          end
        end
        ST_FINISH: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      race_en_q    <= 1'b0;
      cd_q         <= '0;
      step_q       <= '0;
      next_cp_q    <= CPW'(1);
      lap_count_q  <= '0;
      lap_time_q   <= '0;
      last_q       <= '0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
      go_q         <= 1'b0;
      fin_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      race_en_q    <= bus.race_en;
      cd_q         <= cd_d;
      step_q       <= step_d;
      next_cp_q    <= next_cp_d;
      lap_count_q  <= lap_count_d;
      lap_time_q   <= lap_time_d;
      last_q       <= last_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      go_q         <= go_d;
      fin_q        <= fin_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.cd_digit      = cd_q;
  assign bus.go            = go_q;
  assign bus.player_enable = (state_q == ST_RACE);
  assign bus.lap_count     = lap_count_q;
  assign bus.lap_time_ms   = lap_time_q;
  assign bus.last_lap_ms   = last_q;
  assign bus.best_lap_ms   = best_q;
  assign bus.best_valid    = best_valid_q;
  assign bus.finished      = fin_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer: countdown, lap ordering, best lap, abort, reset, saturation.
// Instance 0 uses 20-bit times, instance 1 uses 4-bit times for saturation.
module tb_race_sequencer;

  logic pclk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  race_sequencer_if #(.NUM_CP(4), .TW(20)) b0 ();
  race_sequencer_if #(.NUM_CP(4), .TW(4))  b1 ();

  race_sequencer #(.TICK_DIV(4), .STEP_MS(2), .NUM_CP(4), .NUM_LAPS(3), .TW(20)) u0 (
    .pclk (pclk), .rst (rst), .bus (b0)
  );
  race_sequencer #(.TICK_DIV(4), .STEP_MS(2), .NUM_CP(4), .NUM_LAPS(3), .TW(4)) u1 (
    .pclk (pclk), .rst (rst), .bus (b1)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int which;
    int cnt;
    int last;
    int best;
    int bv;
    int fin;
    int st;
    int lt;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic pulse(input int which, input logic [3:0] m);
    if (which == 0) b0.cp_hit = m; else b1.cp_hit = m;
    cyc(1);
    if (which == 0) b0.cp_hit = '0; else b1.cp_hit = '0;
  endtask

  task automatic push(input int which, input int cnt, input int last, input int best,
                      input int bv, input int fin, input int st);
    exp_t e;
    e.which = which; e.cnt = cnt; e.last = last; e.best = best;
    e.bv = bv; e.fin = fin; e.st = st; e.lt = 0;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.which == 0) begin
        chk("sb_lap_count", 32'(b0.lap_count),   e.cnt);
        chk("sb_last",      32'(b0.last_lap_ms), e.last);
        chk("sb_best",      32'(b0.best_lap_ms), e.best);
        chk("sb_best_vld",  32'(b0.best_valid),  e.bv);
        chk("sb_finished",  32'(b0.finished),    e.fin);
        chk("sb_state",     32'(b0.state),       e.st);
        chk("sb_lap_time",  32'(b0.lap_time_ms), e.lt);
      end else begin
        chk("sb1_lap_count", 32'(b1.lap_count),   e.cnt);
        chk("sb1_last",      32'(b1.last_lap_ms), e.last);
        chk("sb1_best",      32'(b1.best_lap_ms), e.best);
        chk("sb1_best_vld",  32'(b1.best_valid),  e.bv);
        chk("sb1_state",     32'(b1.state),       e.st);
      end
    end
  endtask

  task automatic wait_lap_time(input int v);
    int n = 0;
    while (b0.lap_time_ms !== 20'(v) && n < 200) begin
      cyc(1);
      n++;
    end
    chk("wait_lap_time", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_state(input int which, input logic [1:0] s);
    int n = 0;
    while (((which == 0) ? b0.state : b1.state) !== s && n < 60) begin
      cyc(1);
      n++;
    end
    chk("wait_state", 32'(n < 60), 32'd1);
  endtask

  task automatic lap(input int ms, input int cnt, input int last, input int best,
                     input int fin, input int st);
    pulse(0, 4'b0010);
    pulse(0, 4'b0100);
    pulse(0, 4'b1000);
    wait_lap_time(ms);
    b0.cp_hit = 4'b0001;
    push(0, cnt, last, best, 1, fin, st);
    cyc(1);
    b0.cp_hit = '0;
    sb_check();
  endtask

  initial begin
    rst = 1'b0;
    b0.race_en = 1'b0; b0.cp_hit = '0;
    b1.race_en = 1'b0; b1.cp_hit = '0;
    #2;
    chk("rst_state",    32'(b0.state),       32'd0);
    chk("rst_cd",       32'(b0.cd_digit),    32'd0);
    chk("rst_pe",       32'(b0.player_enable), 32'd0);
    chk("rst_best_vld", 32'(b0.best_valid),  32'd0);
    chk("rst1_state",   32'(b1.state),       32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    b0.race_en = 1'b1;

    // Countdown: m counts negedges after race_en rose.
    for (int m = 1; m <= 26; m++) begin
      cyc(1);
      if (m == 1)  begin chk("cd_enter_state", 32'(b0.state), 32'd1); chk("cd_enter_digit", 32'(b0.cd_digit), 32'd3); end
      if (m == 8)  chk("cd_digit_m8",  32'(b0.cd_digit), 32'd3);
      if (m == 9)  chk("cd_digit_m9",  32'(b0.cd_digit), 32'd2);
      if (m == 17) chk("cd_digit_m17", 32'(b0.cd_digit), 32'd1);
      if (m == 24) begin
        chk("pre_go_state", 32'(b0.state), 32'd1);
        chk("pre_go_go",    32'(b0.go), 32'd0);
        chk("pre_go_pe",    32'(b0.player_enable), 32'd0);
      end
      if (m == 25) begin
        chk("go_state", 32'(b0.state), 32'd2);
        chk("go_pulse", 32'(b0.go), 32'd1);
        chk("go_pe",    32'(b0.player_enable), 32'd1);
        chk("go_cd",    32'(b0.cd_digit), 32'd0);
        chk("go_lt",    32'(b0.lap_time_ms), 32'd0);
      end
      if (m == 26) chk("go_once", 32'(b0.go), 32'd0);
    end

    // Lap 1 with out-of-order, premature and repeated hits.
    pulse(0, 4'b0100);
    pulse(0, 4'b0010);
    pulse(0, 4'b0001);
    chk("premature_cp0", 32'(b0.lap_count), 32'd0);
    pulse(0, 4'b0010);
    pulse(0, 4'b0100);
    pulse(0, 4'b1000);
    chk("before_final_cp0", 32'(b0.lap_count), 32'd0);
    wait_lap_time(10);
    b0.cp_hit = 4'b0001;
    push(0, 1, 10, 10, 1, 0, 2);
    cyc(1);
    b0.cp_hit = '0;
    sb_check();

    lap(7, 2, 7, 7, 0, 2);
    lap(7, 3, 7, 7, 1, 3);
    chk("finish_pe", 32'(b0.player_enable), 32'd0);
    cyc(1);
    chk("finish_once", 32'(b0.finished), 32'd0);
    cyc(10);
    chk("finish_hold_state", 32'(b0.state), 32'd3);
    chk("finish_hold_lt",    32'(b0.lap_time_ms), 32'd0);
    chk("finish_hold_fin",   32'(b0.finished), 32'd0);

    // Leave FINISH, then restart.
    b0.race_en = 1'b0;
    cyc(1);
    chk("idle_state",    32'(b0.state), 32'd0);
    chk("idle_lc",       32'(b0.lap_count), 32'd0);
    chk("idle_best",     32'(b0.best_lap_ms), 32'd7);
    chk("idle_best_vld", 32'(b0.best_valid), 32'd1);
    b0.race_en = 1'b1;
    cyc(1);
    chk("restart_state", 32'(b0.state), 32'd1);
    chk("restart_cd",    32'(b0.cd_digit), 32'd3);
    wait_state(0, 2'd2);

    // All bits at once advances only from 1 to 2.
    pulse(0, 4'b1111);
    pulse(0, 4'b1000);
    pulse(0, 4'b0001);
    chk("multi_hit_one_adv", 32'(b0.lap_count), 32'd0);
    pulse(0, 4'b0100);
    pulse(0, 4'b1000);
    wait_lap_time(5);
    b0.race_en = 1'b0;
    b0.cp_hit  = 4'b0001;
    push(0, 0, 7, 7, 1, 0, 0);
    cyc(1);
    b0.cp_hit = '0;
    sb_check();

    b0.race_en = 1'b1;
    cyc(1);
    chk("restart2_cd", 32'(b0.cd_digit), 32'd3);
    cyc(5);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state",    32'(b0.state), 32'd0);
    chk("arst_cd",       32'(b0.cd_digit), 32'd0);
    chk("arst_best",     32'(b0.best_lap_ms), 32'd0);
    chk("arst_best_vld", 32'(b0.best_valid), 32'd0);
    chk("arst_last",     32'(b0.last_lap_ms), 32'd0);
    chk("arst_lc",       32'(b0.lap_count), 32'd0);
    b0.race_en = 1'b0;
    cyc(1);
    rst = 1'b1;

    // Saturation on the 4-bit instance.
    b1.race_en = 1'b1;
    cyc(1);
    wait_state(1, 2'd2);
    cyc(90);
    chk("sat_lt",    32'(b1.lap_time_ms), 32'd15);
    chk("sat_state", 32'(b1.state), 32'd2);
    pulse(1, 4'b0010);
    pulse(1, 4'b0100);
    pulse(1, 4'b1000);
    b1.cp_hit = 4'b0001;
    push(1, 1, 15, 15, 1, 0, 2);
    cyc(1);
    b1.cp_hit = '0;
    sb_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/race_sequencer.md
# race_sequencer

Sequences one race after the menu FSM enters the game state. It runs a 3-2-1 start countdown, then gates player movement. It counts laps by enforcing checkpoint order and times each lap in milliseconds, keeping last and best lap. It asserts a finish condition after the configured lap count, and its outputs feed the HUD/timer display and the player-motion block.

## Interface
Parameters:
- TICK_DIV, 65000 — pclk cycles per millisecond tick (65 MHz pixel clock)
- STEP_MS, 1000 — duration of each countdown digit, in ms
- NUM_CP, 4 — checkpoints per lap; index 0 is the start/finish line
- NUM_LAPS, 3 — laps to finish the race
- TW, 20 — width of the ms time fields

Ports:
- pclk  input  1  system clock
- rst  input  1  reset
  - One clock; reset is asynchronous and active-low.
- race_en  input  1  level from the main FSM, high while in the game state
- cp_hit  input  NUM_CP  per-checkpoint crossing pulses from track collision logic
- state  output  2  IDLE=0, COUNTDOWN=1, RACE=2, FINISH=3
- cd_digit  output  2  countdown digit shown (3, 2, 1); 0 outside COUNTDOWN
- go  output  1  one-cycle pulse on COUNTDOWN→RACE
- player_enable  output  1  high only in RACE
- lap_count  output  2  completed laps
- lap_time_ms  output  TW  running time of the current lap
- last_lap_ms  output  TW  time of the most recently completed lap
- best_lap_ms  output  TW  fastest completed lap
- best_valid  output  1  high once at least one lap has completed
- finished  output  1  one-cycle pulse on RACE→FINISH

## Operation
- Reset values: state=IDLE, all other outputs 0; internal next_cp=1, prescaler=0, step counter=0.
- race_en low in any state forces IDLE on the next edge.
  - Clears cd_digit, lap_count, lap_time_ms, next_cp.
  - Retains last_lap_ms, best_lap_ms and best_valid.
- IDLE: a race_en rising edge (race_en=1 and its registered copy=0) moves to COUNTDOWN.
  - cd_digit=3; prescaler and step counter cleared; lap fields cleared.
  - If race_en is already high, nothing happens until it has been low for at least one cycle.
- COUNTDOWN: the step counter counts ms ticks; after STEP_MS ticks cd_digit decrements.
  - When digit 1 expires: go to RACE, pulse go, cd_digit=0, lap_time_ms=0.
- RACE:
  - lap_time_ms increments on each ms tick and saturates at 2^TW-1.
  - A cp_hit[next_cp] pulse advances next_cp. Other bits are ignored, including hits out of order or repeated.
  - cp_hit[0] completes a lap only when next_cp==NUM_CP. A premature cp_hit[0] is ignored.
  - On lap completion:
    - last_lap_ms ← lap_time_ms.
    - best_lap_ms ← lap_time_ms if !best_valid or lap_time_ms < best_lap_ms. A tie keeps the old value.
    - best_valid ← 1; lap_count++; next_cp ← 1; lap_time_ms ← 0.
  - If a tick coincides with lap completion, the stored time excludes that tick.
  - When lap_count reaches NUM_LAPS, go to FINISH and pulse finished.
- FINISH: all fields frozen, player_enable=0. Stays until race_en goes low.
- Simultaneous events:
  - race_en low beats lap completion and countdown expiry.
  - Several cp_hit bits in one cycle: only the expected bit counts, and only one advance is made per cycle.
- Asynchronous reset mid-race returns everything to reset values immediately, including best lap.

## Timing
- Prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick at TICK_DIV-1.
  - It free-runs in COUNTDOWN and RACE and is held at 0 in IDLE and FINISH.
  - It is not cleared at lap boundaries.
- The race_en edge is registered, giving IDLE→COUNTDOWN 1 cycle after race_en rises.
- go and player_enable rise on the same edge as state=RACE, exactly 3·STEP_MS·TICK_DIV cycles after entering COUNTDOWN.
- A cp_hit pulse updates outputs on the next pclk edge; there is no additional latency.
- All outputs are registered and there are no combinational input→output paths.

## Structure
- Package race_pkg holds:
  - the state encoding localparams (IDLE/COUNTDOWN/RACE/FINISH);
  - the default TW, NUM_CP and NUM_LAPS;
  - the countdown start value 3.
- Sub-module ms_tick_gen holds the TICK_DIV prescaler with an enable/clear input and a tick output. It is reusable by the HUD clock.
- Single next-state always block plus one registered block, matching the main FSM's _nxt style.

## Test plan
Bench parameters: TICK_DIV=4, STEP_MS=2, NUM_CP=4, NUM_LAPS=3.
- Countdown: rst released, race_en 0→1 → COUNTDOWN next cycle, cd_digit 3→2→1 every 8 cycles; go pulse and player_enable=1 at cycle 25.
- Lap ordering: in RACE, hits cp 2, 1, 0, 1, 2, 3, 0 → first 0 ignored, 2 before 1 ignored, lap_count=1 only after the final 0.
- Best lap: laps of 10, 7, 7 ms → last_lap_ms 10, 7, 7; best_lap_ms 10→7, and the tie keeps 7; finished pulses once after lap 3, state=FINISH, player_enable=0.
- Abort: race_en low mid-lap with lap_time_ms=5 → IDLE next cycle, lap_time_ms=0, best_lap_ms retained; race_en high again restarts at cd_digit=3.
- Simultaneous: cp_hit=4'b1111 with next_cp=1 → next_cp=2 only. cp_hit[0] on the same cycle as race_en falling → IDLE, lap_count unchanged.
- Saturation: TW=4, hold a lap for 20 ms → lap_time_ms sticks at 15.
- Async reset mid-COUNTDOWN: all outputs 0 immediately, without waiting for a clock edge.
